// File: rtl/accel_pkg.sv
// Shared accelerator constants and types used by the vector port arbiter.
// Vector addresses are {unit_id, vector_index}: 2 + 4 bits.
package accel_pkg;

  localparam int VECTOR_WIDTH = 32;
  localparam int VEC_UNITS    = 4;
  localparam int VEC_IDX_W    = 4;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  typedef logic [5:0] vec_addr_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-one finder.
// Searches req starting at ptr, wrapping modulo N. N must be a power of two.
module rr_pick
  import accel_pkg::*;
#(
  parameter int N = VEC_UNITS,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [W-1:0] cand;

  // Walk the search order backwards so the nearest hit to ptr is the last write.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = ptr + W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/vector_port_arbiter.sv
// Round-robin arbiter sharing memory port A between NUM_REQ requesters,
// granting bounded bursts and routing the 1-cycle registered response back.
module vector_port_arbiter
  import accel_pkg::*;
#(
  parameter int NUM_REQ      = VEC_UNITS,
  parameter int IDX_W        = VEC_IDX_W,
  parameter int BURST_MAX    = 4,
  parameter int VECTOR_WIDTH = accel_pkg::VECTOR_WIDTH,
  parameter int UID_W        = $clog2(NUM_REQ)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ-1:0]                   req_we,
  input  logic [NUM_REQ-1:0][IDX_W-1:0]        req_idx,
  input  logic [NUM_REQ-1:0][VECTOR_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  output logic [VECTOR_WIDTH-1:0]              rsp_data,
  output logic                                 rsp_err,
  output vec_addr_t                            mem_addr_a,
  output logic                                 mem_we_a,
  output logic [VECTOR_WIDTH-1:0]              mem_data_in_a,
  input  logic [VECTOR_WIDTH-1:0]              mem_data_out_a,
  input  logic                                 mem_err_a,
  output logic [UID_W-1:0]                     grant_id,
  output logic                                 busy
);

  arb_state_t       state;
  logic [UID_W-1:0] owner;
  logic [UID_W-1:0] rr_ptr;
  logic [UID_W-1:0] rsp_owner;
  logic [UID_W-1:0] next_ptr;
  logic [UID_W-1:0] pick_idx;
  logic [3:0]       beat_cnt;
  logic             rsp_pend;
  logic             pick_found;
  logic             own;
  logic             owner_valid;
  logic             beat;
  logic             cap_hit;

  rr_pick #(
    .N (NUM_REQ),
    .W (UID_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign own         = (state == OWN);
  assign owner_valid = req_valid[owner];
  assign beat        = own & owner_valid;
  assign cap_hit     = (beat_cnt == 4'(BURST_MAX - 1));
  assign next_ptr    = (owner == UID_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  always_comb begin
    req_ready = '0;
    if (own) req_ready[owner] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (rsp_pend) rsp_valid[rsp_owner] = 1'b1;
  end

  // The index lane is masked when no beat is offered so the address idles at {owner, 0}.
  assign mem_addr_a    = {owner, (beat ? req_idx[owner] : {IDX_W{1'b0}})};
  assign mem_we_a      = beat & req_we[owner];
  assign mem_data_in_a = own ? req_wdata[owner] : '0;

  assign rsp_data = mem_data_out_a;
  assign rsp_err  = mem_err_a;
  assign busy     = own;
  assign grant_id = owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      rsp_pend  <= 1'b0;
      rsp_owner <= '0;
    end else begin
      rsp_pend <= beat;
      if (beat) rsp_owner <= owner;
      case (state)
        IDLE: begin
          if (pick_found) begin
            owner    <= pick_idx;
            beat_cnt <= '0;
            state    <= OWN;
          end
        end
        OWN: begin
          if (!owner_valid) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end else begin
            beat_cnt <= beat_cnt + 4'd1;
            // The cap beat itself is accepted; rotation happens right after it.
            if (cap_hit) begin
              state  <= IDLE;
              rr_ptr <= next_ptr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_port_arbiter.sv
// Self-checking bench for vector_port_arbiter: directed vector table, corner
// sequences, and randomized traffic against a memory/scoreboard reference.
module tb_vector_port_arbiter;
  import accel_pkg::*;

  localparam int N          = 4;
  localparam int IW         = 4;
  localparam int BM         = 4;
  localparam int VW         = VECTOR_WIDTH;
  localparam int FAIR_LIMIT = N * (BM + 2);

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [N-1:0]             req_valid;
  logic [N-1:0]             req_ready;
  logic [N-1:0]             req_we;
  logic [N-1:0][IW-1:0]     req_idx;
  logic [N-1:0][VW-1:0]     req_wdata;
  logic [N-1:0]             rsp_valid;
  logic [VW-1:0]            rsp_data;
  logic                     rsp_err;
  vec_addr_t                mem_addr_a;
  logic                     mem_we_a;
  logic [VW-1:0]            mem_data_in_a;
  logic [VW-1:0]            mem_data_out_a;
  logic                     mem_err_a;
  logic [1:0]               grant_id;
  logic                     busy;
  logic                     err_inject;

  logic [VW-1:0]            mem_model [64];
  logic [VW-1:0]            ref_mem [64];

  int                       checks = 0;
  int                       failures = 0;

  int                       remaining [N];
  int                       wait_cnt [N];
  logic [N-1:0]             beat_last;
  logic                     pend;
  logic [N-1:0]             pend_mask;
  logic [VW-1:0]            pend_data;
  logic                     pend_err;
  int                       run_len;
  int                       last_id;
  int                       grant_seq [$];

  typedef struct {
    int          id;
    logic [3:0]  idx;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  exp_ready;
    logic [5:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t table_v [7];

  vector_port_arbiter #(
    .NUM_REQ   (N),
    .IDX_W     (IW),
    .BURST_MAX (BM)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_idx        (req_idx),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .mem_addr_a     (mem_addr_a),
    .mem_we_a       (mem_we_a),
    .mem_data_in_a  (mem_data_in_a),
    .mem_data_out_a (mem_data_out_a),
    .mem_err_a      (mem_err_a),
    .grant_id       (grant_id),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Registered write-through memory standing in for shared_memory_unit port A.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < 64; a++) mem_model[a] <= '0;
      mem_data_out_a <= '0;
      mem_err_a      <= 1'b0;
    end else begin
      if (mem_we_a) begin
        mem_model[mem_addr_a] <= mem_data_in_a;
        mem_data_out_a        <= mem_data_in_a;
      end else begin
        mem_data_out_a <= mem_model[mem_addr_a];
      end
      mem_err_a <= err_inject;
    end
  end

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic raise(input int id, input logic [3:0] idx, input logic we, input logic [31:0] wdata);
    req_valid[id] = 1'b1;
    req_idx[id]   = idx;
    req_we[id]    = we;
    req_wdata[id] = wdata;
  endtask

  task automatic lower(input int id);
    req_valid[id] = 1'b0;
    req_we[id]    = 1'b0;
  endtask

  task automatic new_payload(input int id);
    req_we[id]    = 1'($urandom_range(1));
    req_idx[id]   = 4'($urandom);
    req_wdata[id] = $urandom;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    req_valid  = '0;
    req_we     = '0;
    req_idx    = '0;
    req_wdata  = '0;
    err_inject = 1'b0;
    for (int a = 0; a < 64; a++) ref_mem[a] = '0;
    for (int i = 0; i < N; i++) begin
      remaining[i] = 0;
      wait_cnt[i]  = 0;
    end
    beat_last = '0;
    pend      = 1'b0;
    run_len   = 0;
    last_id   = -1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives requester traffic and scores every beat/response against ref_mem.
  task automatic apply_stimulus(input int max_cycles, input bit rand_mode, input int rand_cycles);
    bit            done;
    int            id;
    logic [5:0]    addr;
    done = 1'b0;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      @(negedge clk);
      if (pend) begin
        check_output("rsp_valid", rsp_valid, pend_mask);
        check_output("rsp_data", rsp_data, pend_data);
        check_output("rsp_err", rsp_err, pend_err);
      end else begin
        check_output("rsp_quiet", rsp_valid, 0);
      end
      pend = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (beat_last[i]) begin
          remaining[i]--;
          if (remaining[i] == 0) lower(i);
          else if (rand_mode) new_payload(i);
        end else if (rand_mode && cyc < rand_cycles && !req_valid[i] && $urandom_range(3) == 0) begin
          remaining[i] = $urandom_range(1, 6);
          new_payload(i);
          req_valid[i] = 1'b1;
        end
      end
      err_inject = rand_mode && ($urandom_range(7) == 0);
      #1;
      check_output("ready_onehot", $onehot0(req_ready), 1);
      check_output("busy_vs_ready", busy, (req_ready != '0));
      for (int i = 0; i < N; i++) begin
        if (req_ready[i] && wait_cnt[i] > 0) begin
          check_output("fairness", (wait_cnt[i] <= FAIR_LIMIT), 1);
          wait_cnt[i] = 0;
        end else if (req_valid[i] && !req_ready[i]) begin
          wait_cnt[i]++;
        end else begin
          wait_cnt[i] = 0;
        end
      end
      beat_last = req_valid & req_ready;
      if (beat_last != '0) begin
        id = 0;
        for (int i = 0; i < N; i++) if (beat_last[i]) id = i;
        addr = {2'(id), req_idx[id]};
        check_output("mem_addr", mem_addr_a, addr);
        check_output("mem_we", mem_we_a, req_we[id]);
        if (req_we[id]) begin
          check_output("mem_wdata", mem_data_in_a, req_wdata[id]);
          ref_mem[addr] = req_wdata[id];
        end
        pend      = 1'b1;
        pend_mask = beat_last;
        pend_data = ref_mem[addr];
        pend_err  = err_inject;
        grant_seq.push_back(id);
        run_len   = (id == last_id) ? run_len + 1 : 1;
        last_id   = id;
        check_output("burst_cap", (run_len <= BM), 1);
      end else begin
        run_len = 0;
        last_id = -1;
      end
      if (req_valid == '0 && beat_last == '0 && !pend && cyc >= rand_cycles) begin
        done = 1'b1;
        break;
      end
    end
    check_output("traffic_drained", done, 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    table_v[0] = '{2, 4'd3,  1'b1, 32'h0000_00A5, 4'b0100, 6'h23, 32'h0000_00A5};
    table_v[1] = '{2, 4'd3,  1'b0, 32'h0,         4'b0100, 6'h23, 32'h0000_00A5};
    table_v[2] = '{0, 4'd6,  1'b1, 32'h0000_0077, 4'b0001, 6'h06, 32'h0000_0077};
    table_v[3] = '{3, 4'd15, 1'b1, 32'hDEAD_BEEF, 4'b1000, 6'h3F, 32'hDEAD_BEEF};
    table_v[4] = '{1, 4'd0,  1'b0, 32'h0,         4'b0010, 6'h10, 32'h0};
    table_v[5] = '{0, 4'd6,  1'b0, 32'h0,         4'b0001, 6'h06, 32'h0000_0077};
    table_v[6] = '{3, 4'd15, 1'b0, 32'h0,         4'b1000, 6'h3F, 32'hDEAD_BEEF};

    rst_n      = 1'b0;
    req_valid  = '0;
    req_we     = '0;
    req_idx    = '0;
    req_wdata  = '0;
    err_inject = 1'b0;
    #1;
    check_output("rst_ready", req_ready, 0);
    check_output("rst_rsp_valid", rsp_valid, 0);
    check_output("rst_mem_we", mem_we_a, 0);
    check_output("rst_mem_addr", mem_addr_a, 0);
    check_output("rst_mem_wdata", mem_data_in_a, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_grant_id", grant_id, 0);
    apply_reset();

    // Single-beat transactions, one at a time from IDLE.
    for (int t = 0; t < 7; t++) begin
      @(negedge clk);
      raise(table_v[t].id, table_v[t].idx, table_v[t].we, table_v[t].wdata);
      #1 check_output("tbl_ready_c0", req_ready, 0);
      @(negedge clk);
      #1;
      check_output("tbl_ready_c1", req_ready, table_v[t].exp_ready);
      check_output("tbl_addr", mem_addr_a, table_v[t].exp_addr);
      check_output("tbl_we", mem_we_a, table_v[t].we);
      @(negedge clk);
      check_output("tbl_rsp_valid", rsp_valid, table_v[t].exp_ready);
      check_output("tbl_rsp_data", rsp_data, table_v[t].exp_data);
      check_output("tbl_rsp_err", rsp_err, 0);
      lower(table_v[t].id);
      @(negedge clk);
      check_output("tbl_rsp_done", rsp_valid, 0);
      check_output("tbl_idle", busy, 0);
    end

    // Write then read idx 5 within one burst of requester 0.
    @(negedge clk);
    raise(0, 4'd5, 1'b1, 32'h3C);
    @(negedge clk);
    #1;
    check_output("wr_addr", mem_addr_a, 6'h05);
    check_output("wr_we", mem_we_a, 1);
    check_output("wr_data", mem_data_in_a, 32'h3C);
    @(negedge clk);
    check_output("wr_rsp_valid", rsp_valid, 4'b0001);
    check_output("wr_rsp_data", rsp_data, 32'h3C);
    req_we[0] = 1'b0;
    #1;
    check_output("rd_addr", mem_addr_a, 6'h05);
    check_output("rd_we", mem_we_a, 0);
    @(negedge clk);
    check_output("rd_rsp_valid", rsp_valid, 4'b0001);
    check_output("rd_rsp_data", rsp_data, 32'h3C);
    lower(0);
    @(negedge clk);
    check_output("wr_rd_done", rsp_valid, 0);

    // Memory error forwarded on the first read response only.
    @(negedge clk);
    raise(2, 4'd3, 1'b0, 32'h0);
    @(negedge clk);
    #1 check_output("err_ready", req_ready, 4'b0100);
    err_inject = 1'b1;
    @(negedge clk);
    check_output("err_rsp_valid", rsp_valid, 4'b0100);
    check_output("err_set", rsp_err, 1);
    check_output("err_data", rsp_data, 32'hA5);
    err_inject = 1'b0;
    @(negedge clk);
    check_output("err_rsp_valid2", rsp_valid, 4'b0100);
    check_output("err_clear", rsp_err, 0);
    lower(2);
    @(negedge clk);
    check_output("err_idle", busy, 0);
    raise(1, 4'd2, 1'b0, 32'h0);
    @(negedge clk);
    #1 check_output("err_continue", req_ready, 4'b0010);
    @(negedge clk);
    check_output("err_continue_rsp", rsp_valid, 4'b0010);
    lower(1);

    // All four requesters, one beat each: grants rotate 0,1,2,3.
    apply_reset();
    for (int i = 0; i < N; i++) begin
      raise(i, 4'(i), 1'b0, 32'h0);
      remaining[i] = 1;
    end
    grant_seq.delete();
    apply_stimulus(60, 1'b0, 0);
    check_output("rr_count", grant_seq.size(), 4);
    for (int i = 0; i < 4 && i < grant_seq.size(); i++)
      check_output($sformatf("rr_order_%0d", i), grant_seq[i], i);

    // Long burst from 1 competing with a single beat from 3.
    apply_reset();
    raise(1, 4'd7, 1'b0, 32'h0);
    raise(3, 4'd2, 1'b0, 32'h0);
    remaining[1] = 10;
    remaining[3] = 1;
    grant_seq.delete();
    apply_stimulus(80, 1'b0, 0);
    begin
      int exp_seq [11] = '{1, 1, 1, 1, 3, 1, 1, 1, 1, 1, 1};
      check_output("burst_count", grant_seq.size(), 11);
      for (int i = 0; i < 11 && i < grant_seq.size(); i++)
        check_output($sformatf("burst_order_%0d", i), grant_seq[i], exp_seq[i]);
    end

    // Reset in the middle of a burst owned by requester 3 (rr_ptr was 3).
    apply_reset();
    @(negedge clk);
    raise(2, 4'd1, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    lower(2);
    @(negedge clk);
    raise(3, 4'd9, 1'b1, 32'h1111_2222);
    @(negedge clk);
    #1 check_output("mid_ready", req_ready, 4'b1000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_ready", req_ready, 0);
    check_output("mid_rst_busy", busy, 0);
    check_output("mid_rst_we", mem_we_a, 0);
    check_output("mid_rst_rsp", rsp_valid, 0);
    check_output("mid_rst_grant", grant_id, 0);
    lower(3);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_output("post_rst_rsp", rsp_valid, 0);
      check_output("post_rst_busy", busy, 0);
    end
    raise(3, 4'd1, 1'b0, 32'h0);
    raise(0, 4'd1, 1'b0, 32'h0);
    @(negedge clk);
    #1 check_output("post_rst_rr_ptr", req_ready, 4'b0001);
    @(negedge clk);
    check_output("post_rst_rsp_new", rsp_valid, 4'b0001);
    lower(0);
    lower(3);

    // Randomized traffic against the scoreboard.
    apply_reset();
    apply_stimulus(3000, 1'b1, 2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
